tube_frame_scheduler: RTL

Sequences the 8-digit seven-segment display for the piano's mode screens (idle banner, play/recording note readout). Requesters submit complete 8-digit frames through a valid/ready handshake. The block double-buffers each frame and swaps it in only at a scan-frame boundary, so the display never tears. It time-multiplexes digit pairs onto the left and right segment buses, with a blanking gap between slots to suppress ghosting.

---
 rtl/tube_frame_scheduler_pkg.sv | 34 +++
 rtl/tube_scan_timer.sv | 29 ++
 rtl/tube_frame_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tube_frame_scheduler_pkg.sv
// Shared codes and state encoding for the seven-segment frame scheduler.
// Glyph codes use bit order {dp,g,f,e,d,c,b,a}.
package tube_frame_scheduler_pkg;

  localparam logic [7:0] SEG_NULL = 8'h00;
  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_A    = 8'h77;
  localparam logic [7:0] SEG_C    = 8'h39;
  localparam logic [7:0] SEG_D    = 8'h5E;
  localparam logic [7:0] SEG_E    = 8'h79;
  localparam logic [7:0] SEG_F    = 8'h71;
  localparam logic [7:0] SEG_G    = 8'h3D;
  localparam logic [7:0] SEG_DASH = 8'h40;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tube_scan_timer.sv
// Phase timer: counts cycles within the current BLANK/SHOW phase and flags
// the last cycle of that phase. load forces the next count to zero.
module tube_scan_timer #(
  parameter int W            = 3,
  parameter int DIV_CYCLES   = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         show,
  output logic [W-1:0] count_next,
  output logic         tc
);

  localparam logic [W-1:0] DIV_LAST   = W'(DIV_CYCLES - 1);
  localparam logic [W-1:0] BLANK_LAST = W'(BLANK_CYCLES - 1);

  logic [W-1:0] count;

  assign count_next = load ? '0 : count + W'(1);
  assign tc         = (count == (show ? DIV_LAST : BLANK_LAST));

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/tube_frame_scheduler.sv
// Double-buffered 8-digit seven-segment scanner: frames land in a pending
// buffer and swap into the displayed buffer only at a scan boundary.
module tube_frame_scheduler
  import tube_frame_scheduler_pkg::*;
#(
  parameter int         DIV_CYCLES   = 100000,
  parameter int         BLANK_CYCLES = 1000,
  parameter logic [7:0] BLANK_CODE   = SEG_NULL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_outl,
  output logic [7:0]  seg_outr,
  output logic        frame_done
);

  localparam int             W        = $clog2(max_int(DIV_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [W-1:0]   DIV_LAST = W'(DIV_CYCLES - 1);

  state_t          state, state_d;
  logic [1:0]      slot, slot_d;
  logic            load, tc;
  logic [W-1:0]    count_next;

  logic [63:0]     pending;
  logic            pending_full;
  logic [7:0][7:0] shadow;
  logic            boundary, xfer;

  logic [7:0]      en_d, outl_d, outr_d;
  logic            done_d;

  tube_scan_timer #(
    .W            (W),
    .DIV_CYCLES   (DIV_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .show       (state == S_SHOW),
    .count_next (count_next),
    .tc         (tc)
  );

  // Last cycle of SHOW slot 3 closes the scan frame.
  assign boundary = (state == S_SHOW) && (slot == 2'd3) && tc;
  assign xfer     = pending_full && ((state == S_IDLE) || (boundary && enable));

  always_comb begin
    state_d = state;
    slot_d  = slot;
    if (!enable) begin
      state_d = S_IDLE;
      slot_d  = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state_d = S_BLANK;
          slot_d  = 2'd0;
        end
        S_BLANK: if (tc) state_d = S_SHOW;
        S_SHOW: if (tc) begin
          state_d = S_BLANK;
          slot_d  = slot + 2'd1;
        end
        default: begin
          state_d = S_IDLE;
          slot_d  = 2'd0;
        end
      endcase
    end
    load = (state_d != state) || (state_d == S_IDLE);
  end

  // Outputs are computed from the next state so they line up with it.
  // ~slot_d selects digit 3-k; with bit 2 set it selects 7-k.
  always_comb begin
    en_d   = '0;
    outl_d = BLANK_CODE;
    outr_d = BLANK_CODE;
    done_d = 1'b0;
    if (state_d == S_SHOW) begin
      en_d[{1'b1, ~slot_d}] = 1'b1;
      en_d[{1'b0, ~slot_d}] = 1'b1;
      outl_d = shadow[{1'b1, ~slot_d}];
      outr_d = shadow[{1'b0, ~slot_d}];
      done_d = (slot_d == 2'd3) && (count_next == DIV_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      slot       <= 2'd0;
      seg_en     <= '0;
      seg_outl   <= BLANK_CODE;
      seg_outr   <= BLANK_CODE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      slot       <= slot_d;
      seg_en     <= en_d;
      seg_outl   <= outl_d;
      seg_outr   <= outr_d;
      frame_done <= done_d;
    end
  end

  // Capture needs an empty pending buffer and transfer needs a full one,
  // so the two never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      pending_full <= 1'b0;
      shadow       <= {8{BLANK_CODE}};
    end else if (frame_valid && !pending_full) begin
      pending      <= frame_data;
      pending_full <= 1'b1;
    end else if (xfer) begin
      shadow       <= pending;
      pending_full <= 1'b0;
    end
  end

  assign frame_ready = !pending_full;

endmodule
